// File: rtl/hilo_divider.sv
// hilo_divider: sequential restoring divider producing quotient (LO) and
// remainder (HI) for DIV/DIVU. One quotient bit per cycle, fixed latency
// of WIDTH+1 cycles, results held until the next operation completes.
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] div_mag;
    logic [WIDTH-1:0] partial_rem;
    logic [WIDTH-1:0] work_quot;
    logic [WIDTH-1:0] raw_dividend;
    logic             q_neg;
    logic             r_neg;
    logic             dz;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Two's complement negate, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of x when treated as signed; raw value otherwise.
    // The most negative value maps onto itself, which is its correct
    // unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             is_signed);
        return (is_signed && x[WIDTH-1]) ? negate(x) : x;
    endfunction

    // Shift-subtract step: subtract by adding the inverted divisor with a
    // carry-in of one, WIDTH+1 bits wide so the MSB is the trial sign.
    assign shifted = {partial_rem, work_quot[WIDTH-1]};
    assign trial   = shifted + {1'b1, ~div_mag} + {{WIDTH{1'b0}}, 1'b1};

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic: fixed WIDTH iterations then one fix-up cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (cnt == LAST) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            div_mag      <= '0;
            partial_rem  <= '0;
            work_quot    <= '0;
            raw_dividend <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            dz           <= 1'b0;
            quot         <= '0;
            rem          <= '0;
            div_zero     <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt          <= '0;
                        div_mag      <= magnitude(divisor, sign);
                        partial_rem  <= '0;
                        work_quot    <= magnitude(dividend, sign);
                        raw_dividend <= dividend;
                        q_neg        <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg        <= sign & dividend[WIDTH-1];
                        dz           <= (divisor == '0);
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (!trial[WIDTH]) partial_rem <= trial[WIDTH-1:0];
                    else               partial_rem <= shifted[WIDTH-1:0];
                    work_quot <= {work_quot[WIDTH-2:0], ~trial[WIDTH]};
                end
                FIX: begin
                    div_zero <= dz;
                    if (dz) begin
                        quot <= '1;
                        rem  <= raw_dividend;
                    end else begin
                        quot <= q_neg ? negate(work_quot) : work_quot;
                        rem  <= r_neg ? negate(partial_rem) : partial_rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_divider.sv
// tb_hilo_divider: directed vectors for hilo_divider; expected results are
// queued at issue time and checked by an independent done monitor.
module tb_hilo_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          e0;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   done_total = 0;
    int   ops_expect = 0;

    hilo_divider #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .sign(sign),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quot(quot), .rem(rem), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_total++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("quot", quot, e.q);
                chk("rem", rem, e.r);
                chk("div_zero", {31'd0, div_zero}, {31'd0, e.z});
                chk("latency", 32'(cyc - e.e0), 32'd33);
            end
        end
    end

    // Drive one start pulse; operands are scrambled right after the edge.
    task automatic issue(input bit now, input bit s, input logic [31:0] dd,
                         input logic [31:0] dv, input logic [31:0] eq,
                         input logic [31:0] er, input bit ez);
        exp_t e;
        if (!now) @(negedge clk);
        sign     = s;
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        e.q = eq; e.r = er; e.z = ez; e.e0 = cyc + 1;
        sb.push_back(e);
        ops_expect++;
        @(negedge clk);
        start    = 1'b0;
        sign     = ~s;
        dividend = 32'hDEADBEEF;
        divisor  = 32'h00000001;
    endtask

    // Wait (bounded) for done, counting cycles with busy high on the way.
    task automatic wait_done(input int busy_exp);
        int n = 0;
        int b = 0;
        while (!done && n < 40) begin
            if (busy) b++;
            @(negedge clk);
            n++;
        end
        if (!done) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            chk("busy_cycles", 32'(b), 32'(busy_exp));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quot", quot, 32'd0);
        chk("rst_rem", rem, 32'd0);
        chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
        rst = 1'b0;

        issue(0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0);               wait_done(33);
        issue(0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0); wait_done(33);
        issue(0, 1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0);    wait_done(33);
        issue(0, 1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 0); wait_done(33);
        issue(0, 0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1); wait_done(33);
        issue(0, 1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678, 1); wait_done(33);
        issue(0, 0, 32'd9, 32'd3, 32'd3, 32'd0, 0);                  wait_done(33);
        issue(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0); wait_done(33);
        issue(0, 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0);    wait_done(33);
        issue(0, 0, 32'd5, 32'd9, 32'd0, 32'd5, 0);                  wait_done(33);

        // Start while busy is ignored; start in the done cycle is accepted.
        issue(0, 0, 32'd1000, 32'd10, 32'd100, 32'd0, 0);
        repeat (9) @(negedge clk);
        sign = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(23);
        issue(1, 1, 32'hFFFFFFF0, 32'd3, 32'hFFFFFFFB, 32'hFFFFFFFF, 0);
        wait_done(33);
        @(negedge clk);
        chk("done_count", 32'(done_total), 32'(ops_expect));
        chk("hold_quot", quot, 32'hFFFFFFFB);

        // Reset in the middle of an operation.
        issue(0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_quot", quot, 32'd0);
        chk("abort_rem", rem, 32'd0);
        chk("abort_div_zero", {31'd0, div_zero}, 32'd0);
        sb.delete();
        ops_expect--;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_done_after_abort", 32'(done_total), 32'(ops_expect));

        issue(0, 0, 32'd100, 32'd7, 32'd14, 32'd2, 0);               wait_done(33);
        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(sb.size()), 32'd0);
        chk("final_done_count", 32'(done_total), 32'(ops_expect));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
